pipe_stage_skid_buffer: RTL
===========================

Name: pipe_stage_skid_buffer

Overview:
Parametrised inter-stage pipeline register. It generalises the fixed 5-field, 16-bit stage buffer to FIELDS fields of WIDTH bits each, packed into one bus. It adds a valid/ready handshake, a 2-entry skid so stalls never create a combinational ready path, and a synchronous flush for branch and exception squash. It sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
WIDTH, 16, bits per field
FIELDS, 5, number of fields carried per entry; payload width is FIELDS*WIDTH
CNT_WIDTH, 16, stall counter width (used only with STALL_COUNT_EN)

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  synchronous reset, active-high
FLUSH  input  1  synchronous squash of all held entries
IN_VALID  input  1  upstream has an entry on IN_DATA
IN_READY  output  1  buffer accepts an entry this cycle
IN_DATA  input  FIELDS*WIDTH  packed entry; field k occupies bits [k*WIDTH +: WIDTH]
OUT_VALID  output  1  OUT_DATA holds a valid entry
OUT_READY  input  1  downstream consumes the entry this cycle
OUT_DATA  output  FIELDS*WIDTH  head entry, driven directly from a register
OCCUPANCY  output  2  number of held entries, 0..2
STALL_COUNT  output  CNT_WIDTH  present only with STALL_COUNT_EN

Behaviour:
- Clocking and reset: one clock, CLK. Reset RST is synchronous and active-high.
- Reset values (RST high at an edge): OCCUPANCY=0, OUT_VALID=0, IN_READY=1, both entry registers (head and skid) =0, so OUT_DATA=0. STALL_COUNT=0.
- RST has priority over FLUSH, which has priority over push and pop.
- Definitions: push = IN_VALID & IN_READY; pop = OUT_VALID & OUT_READY.
- Derived outputs: IN_READY = (OCCUPANCY != 2). OUT_VALID = (OCCUPANCY != 0). Both decode from state only. There is no combinational path from OUT_READY to IN_READY, or from IN_* to OUT_*.
- EMPTY (0):
  - push -> ONE; head <= IN_DATA.
  - otherwise stay in EMPTY.
- ONE (1):
  - push & !pop -> FULL; skid <= IN_DATA.
  - pop & !push -> EMPTY.
  - push & pop -> ONE; head <= IN_DATA.
  - neither -> hold.
- FULL (2):
  - push is impossible because IN_READY=0.
  - pop -> ONE; head <= skid.
  - !pop -> hold.
- Latency and throughput: an entry pushed at edge N appears on OUT_DATA with OUT_VALID=1 after edge N. Sustained throughput is 1 entry/cycle while OUT_READY=1.
- Stall hold: while OUT_VALID=1 and OUT_READY=0, OUT_DATA is stable.
- Ordering: strict FIFO order. No entry is dropped or duplicated.
- FLUSH at an edge: OCCUPANCY <= 0. A concurrent push is discarded. Entry registers keep their contents; OUT_DATA retains its stale value with OUT_VALID=0. IN_READY=1 on the following cycle.
- OUT_DATA when OUT_VALID=0 is defined as the last head value. The bench checks it only after reset (expects 0).
- The field packing has no arithmetic. Fields are transported bit-exact.

Optional Feature:
- Macro: STALL_COUNT_EN.
- Defined: adds port STALL_COUNT[CNT_WIDTH-1:0].
  - Increments at each edge where OUT_VALID=1 and OUT_READY=0.
  - Saturates at all-ones and never wraps.
  - Cleared only by RST; FLUSH does not clear it.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset: RST=1 for 2 edges with IN_VALID=1, IN_DATA=all 0xFFFF fields -> OCCUPANCY=0, OUT_VALID=0, IN_READY=1, OUT_DATA=0.
- Streaming: OUT_READY=1, push fields {0x0001..0x0005}, then {0x0011..0x0015}, on consecutive cycles -> each entry appears 1 cycle after its push, in order, with OCCUPANCY=1 throughout.
- Skid fill: OUT_READY=0, push A={0xA000..} then B={0xB000..} -> OCCUPANCY=2, IN_READY=0, OUT_DATA=A stable. A third IN_VALID is not accepted. Raise OUT_READY -> A then B on consecutive cycles.
- Simultaneous push/pop in ONE: head=0x1234 fields, push 0x5678 fields with OUT_READY=1 -> OCCUPANCY stays 1, OUT_DATA=0x5678 fields next cycle.
- Flush in FULL with concurrent IN_VALID: FLUSH=1 -> next cycle OCCUPANCY=0, OUT_VALID=0, IN_READY=1. The flushed and concurrent entries never appear.
- STALL_COUNT_EN with CNT_WIDTH=4: hold OUT_VALID=1, OUT_READY=0 for 20 cycles -> STALL_COUNT=0xF and stays 0xF. FLUSH leaves it at 0xF; RST clears it to 0.

Source files
------------

// File: rtl/pipe_stage_skid_buffer.sv
// Parametrised inter-stage register with valid/ready handshake, 2-entry skid and flush.
// Optional STALL_COUNT_EN adds a saturating downstream-stall counter port.
module pipe_stage_skid_buffer #(
    parameter int WIDTH     = 16,
    parameter int FIELDS    = 5,
    parameter int CNT_WIDTH = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    FLUSH,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    input  logic [FIELDS*WIDTH-1:0] IN_DATA,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic [FIELDS*WIDTH-1:0] OUT_DATA,
`ifdef STALL_COUNT_EN
    output logic [CNT_WIDTH-1:0]    STALL_COUNT,
`endif
    output logic [1:0]              OCCUPANCY
);

    localparam int DW = FIELDS * WIDTH;

    if (WIDTH < 1 || FIELDS < 1 || CNT_WIDTH < 1) begin : g_bad_params
        $error("pipe_stage_skid_buffer: parameters must be positive");
    end

    // Encoding equals the number of held entries.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [DW-1:0] head_q;
    logic [DW-1:0] skid_q;
    logic          push;
    logic          pop;
    logic          load_head_in;
    logic          load_head_skid;
    logic          load_skid;

    assign IN_READY  = (state_q != FULL);
    assign OUT_VALID = (state_q != EMPTY);
    assign OCCUPANCY = state_q;
    assign OUT_DATA  = head_q;

    assign push = IN_VALID & IN_READY;
    assign pop  = OUT_VALID & OUT_READY;

    always_comb begin
        state_d        = state_q;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        if (FLUSH) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d      = ONE;
                        load_head_in = 1'b1;
                    end
                end
                ONE: begin
                    unique case (1'b1)
                        push && !pop: begin
                            state_d   = FULL;
                            load_skid = 1'b1;
                        end
                        pop && !push: begin
                            state_d = EMPTY;
                        end
                        push && pop: begin
                            load_head_in = 1'b1;
                        end
                        default: ;
                    endcase
                end
                FULL: begin
                    if (pop) begin
                        state_d        = ONE;
                        load_head_skid = 1'b1;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // Entry registers survive a flush; only the occupancy is squashed.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_head_in) begin
                head_q <= IN_DATA;
            end else if (load_head_skid) begin
                head_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= IN_DATA;
            end
        end
    end

`ifdef STALL_COUNT_EN
    logic [CNT_WIDTH-1:0] stall_q;

    assign STALL_COUNT = stall_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_q <= '0;
        end else if (OUT_VALID && !OUT_READY && (stall_q != '1)) begin
            stall_q <= stall_q + CNT_WIDTH'(1);
        end
    end
`endif

endmodule
